// File: rtl/game_board_wb_responder_if.sv
// Wishbone classic bus between board masters (defuser, planter) and the board store.
interface wishbone_if #(
    parameter int unsigned DATA_W = 16
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [7:0]        adr;
    logic [DATA_W-1:0] dat_w;
    logic [DATA_W-1:0] dat_r;
    logic              ack;
    logic              err;

    modport master (
        output cyc, stb, we, adr, dat_w,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w,
        output dat_r, ack, err
    );
endinterface

// File: rtl/game_board_wb_responder.sv
// Wishbone slave owning the 16x16 minesweeper board and its revealed-field count.
// Optional macro BOARD_ADDR_CHECK_EN: answer accesses outside the active board with err.
module game_board_wb_responder #(
    parameter int unsigned BOARD_DIM = 16,
    parameter int unsigned DATA_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    wishbone_if.slave  game_board_wb,
    input  logic       clear_req,
    input  logic [4:0] row_column_number,
    output logic       board_ready,
    output logic [8:0] revealed_cnt
);

    localparam logic [8:0] MaxCnt = 9'(BOARD_DIM * BOARD_DIM);

    typedef enum logic [1:0] {StClear, StIdle, StAccess, StResp} state_e;

    state_e     state;
    logic [7:0] mem [256];
    logic [7:0] idx;
    logic [7:0] adr_q;
    logic [7:0] wdata_q;
    logic       we_q;
    logic       old_rev;
    logic       clear_pend;
    logic       addr_bad;

    logic       mem_we;
    logic [7:0] mem_waddr;
    logic [7:0] mem_wdata;

`ifdef BOARD_ADDR_CHECK_EN
    assign addr_bad = ({1'b0, adr_q[7:4]} >= row_column_number) ||
                      ({1'b0, adr_q[3:0]} >= row_column_number);
`else
    assign addr_bad = 1'b0;
`endif

    // Single write port shared by the clear sweep and bus writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = idx;
        mem_wdata = 8'h00;
        if (rst) begin
            if (state == StClear) begin
                mem_we = 1'b1;
            end else if (state == StResp && we_q && !game_board_wb.err) begin
                mem_we    = 1'b1;
                mem_waddr = adr_q;
                mem_wdata = wdata_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= StClear;
            idx               <= 8'h00;
            adr_q             <= 8'h00;
            wdata_q           <= 8'h00;
            we_q              <= 1'b0;
            old_rev           <= 1'b0;
            clear_pend        <= 1'b0;
            board_ready       <= 1'b0;
            revealed_cnt      <= 9'd0;
            game_board_wb.ack <= 1'b0;
            game_board_wb.err <= 1'b0;
            game_board_wb.dat_r <= '0;
        end else begin
            game_board_wb.ack <= 1'b0;
            game_board_wb.err <= 1'b0;
            unique case (state)
                StClear: begin
                    if (clear_req) begin
                        idx <= 8'h00;
                    end else if (idx == 8'hFF) begin
                        revealed_cnt <= 9'd0;
                        board_ready  <= 1'b1;
                        state        <= StIdle;
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
                StIdle: begin
                    if (clear_req) begin
                        idx         <= 8'h00;
                        board_ready <= 1'b0;
                        state       <= StClear;
                    end else if (game_board_wb.cyc && game_board_wb.stb) begin
                        adr_q   <= game_board_wb.adr;
                        we_q    <= game_board_wb.we;
                        wdata_q <= game_board_wb.dat_w[7:0];
                        state   <= StAccess;
                    end
                end
                StAccess: begin
                    clear_pend <= clear_pend | clear_req;
                    old_rev    <= mem[adr_q][2];
                    if (addr_bad) begin
                        game_board_wb.err   <= 1'b1;
                        game_board_wb.dat_r <= '0;
                    end else begin
                        game_board_wb.ack <= 1'b1;
                        if (!we_q) begin
                            game_board_wb.dat_r <= DATA_W'(mem[adr_q]);
                        end
                    end
                    state <= StResp;
                end
                StResp: begin
                    if (we_q && !game_board_wb.err) begin
                        if (!old_rev && wdata_q[2] && revealed_cnt < MaxCnt) begin
                            revealed_cnt <= revealed_cnt + 9'd1;
                        end else if (old_rev && !wdata_q[2] && revealed_cnt != 9'd0) begin
                            revealed_cnt <= revealed_cnt - 9'd1;
                        end
                    end
                    if (clear_pend || clear_req) begin
                        clear_pend  <= 1'b0;
                        idx         <= 8'h00;
                        board_ready <= 1'b0;
                        state       <= StClear;
                    end else begin
                        state <= StIdle;
                    end
                end
                default: state <= StClear;
            endcase
        end
    end

endmodule

// File: tb/tb_game_board_wb_responder.sv
// Directed bench for game_board_wb_responder (covers BOARD_ADDR_CHECK_EN when defined).
module tb_game_board_wb_responder;

    logic       clk;
    logic       rst;
    logic       clear_req;
    logic [4:0] row_column_number;
    logic       board_ready;
    logic [8:0] revealed_cnt;

    int vectors;
    int miscompares;

    wishbone_if #(.DATA_W(16)) wb ();

    game_board_wb_responder #(
        .BOARD_DIM(16),
        .DATA_W   (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .game_board_wb    (wb.slave),
        .clear_req        (clear_req),
        .row_column_number(row_column_number),
        .board_ready      (board_ready),
        .revealed_cnt     (revealed_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. lat counts edges from the point the board was ready.
    task automatic wb_access(input logic w, input logic [7:0] a, input logic [15:0] d,
                             output logic [15:0] rd, output int lat,
                             output logic got_ack, output logic got_err);
        int n;
        int mark;
        n       = 0;
        mark    = board_ready ? 0 : -1;
        lat     = -1;
        rd      = '0;
        got_ack = 1'b0;
        got_err = 1'b0;
        wb.cyc   = 1'b1;
        wb.stb   = 1'b1;
        wb.we    = w;
        wb.adr   = a;
        wb.dat_w = d;
        while (n < 400) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (mark < 0 && board_ready) mark = n;
            if (wb.ack || wb.err) break;
        end
        if (wb.ack || wb.err) begin
            lat     = (mark < 0) ? -1 : n - mark;
            rd      = wb.dat_r;
            got_ack = wb.ack;
            got_err = wb.err;
        end
        wb.cyc = 1'b0;
        wb.stb = 1'b0;
        wb.we  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("resp_one_cycle", {30'd0, wb.ack, wb.err}, 32'd0);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (n < 400) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (board_ready) break;
        end
    endtask

    initial begin
        logic [15:0] rd;
        int          lat;
        int          n;
        logic        ga;
        logic        ge;

        vectors           = 0;
        miscompares       = 0;
        rst               = 1'b0;
        clear_req         = 1'b0;
        row_column_number = 5'd16;
        wb.cyc            = 1'b0;
        wb.stb            = 1'b0;
        wb.we             = 1'b0;
        wb.adr            = 8'h00;
        wb.dat_w          = 16'h0000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_board_ready", {31'd0, board_ready}, 32'd0);
        check("rst_ack", {31'd0, wb.ack}, 32'd0);
        check("rst_err", {31'd0, wb.err}, 32'd0);
        check("rst_dat_r", {16'd0, wb.dat_r}, 32'd0);
        check("rst_revealed", {23'd0, revealed_cnt}, 32'd0);

        rst = 1'b1;
        wait_ready(n);
        check("clear_cycles", n, 256);

        wb_access(1'b0, 8'h00, 16'h0, rd, lat, ga, ge);
        check("rd00_data", {16'd0, rd}, 32'h0000);
        wb_access(1'b0, 8'hFF, 16'h0, rd, lat, ga, ge);
        check("rdFF_data", {16'd0, rd}, 32'h0000);
        check("revealed_after_clear", {23'd0, revealed_cnt}, 32'd0);

        wb_access(1'b1, 8'h12, 16'h0005, rd, lat, ga, ge);
        check("wr12_lat", lat, 2);
        check("wr12_ack", {31'd0, ga}, 32'd1);
        check("wr12_revealed", {23'd0, revealed_cnt}, 32'd1);
        wb_access(1'b0, 8'h12, 16'h0, rd, lat, ga, ge);
        check("rd12_lat", lat, 2);
        check("rd12_data", {16'd0, rd}, 32'h0005);

        wb_access(1'b1, 8'h12, 16'h0001, rd, lat, ga, ge);
        check("unreveal_cnt", {23'd0, revealed_cnt}, 32'd0);
        wb_access(1'b1, 8'h12, 16'h0004, rd, lat, ga, ge);
        check("reveal_once_cnt", {23'd0, revealed_cnt}, 32'd1);
        wb_access(1'b1, 8'h12, 16'h0004, rd, lat, ga, ge);
        check("reveal_twice_cnt", {23'd0, revealed_cnt}, 32'd1);

        wb_access(1'b1, 8'h45, 16'hABCD, rd, lat, ga, ge);
        check("wr45_revealed", {23'd0, revealed_cnt}, 32'd2);
        wb_access(1'b0, 8'h45, 16'h0, rd, lat, ga, ge);
        check("rd45_upper_zero", {16'd0, rd}, 32'h00CD);

        // Request issued 10 cycles into a clear sweep.
        clear_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear_req = 1'b0;
        check("clear_req_busy", {31'd0, board_ready}, 32'd0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        wb_access(1'b1, 8'h20, 16'h0004, rd, lat, ga, ge);
        check("held_req_lat", lat, 2);
        check("held_req_ack", {31'd0, ga}, 32'd1);
        wb_access(1'b0, 8'h20, 16'h0, rd, lat, ga, ge);
        check("held_write_survives", {16'd0, rd}, 32'h0004);
        check("held_write_revealed", {23'd0, revealed_cnt}, 32'd1);
        wb_access(1'b0, 8'h12, 16'h0, rd, lat, ga, ge);
        check("clear_wiped_12", {16'd0, rd}, 32'h0000);

        // clear_req in the ACCESS cycle of a write to 0x33.
        wb.cyc   = 1'b1;
        wb.stb   = 1'b1;
        wb.we    = 1'b1;
        wb.adr   = 8'h33;
        wb.dat_w = 16'h0004;
        @(posedge clk);
        @(negedge clk);
        clear_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear_req = 1'b0;
        check("wr33_ack", {31'd0, wb.ack}, 32'd1);
        wb.cyc = 1'b0;
        wb.stb = 1'b0;
        wb.we  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("wr33_clear_started", {31'd0, board_ready}, 32'd0);
        check("wr33_revealed", {23'd0, revealed_cnt}, 32'd2);

        // Restart the sweep part-way through.
        repeat (100) @(posedge clk);
        @(negedge clk);
        clear_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear_req = 1'b0;
        wait_ready(n);
        check("restart_clear_cycles", n, 256);
        check("revealed_after_reclear", {23'd0, revealed_cnt}, 32'd0);
        wb_access(1'b0, 8'h33, 16'h0, rd, lat, ga, ge);
        check("rd33_cleared", {16'd0, rd}, 32'h0000);

        row_column_number = 5'd8;
        wb_access(1'b1, 8'h08, 16'h0004, rd, lat, ga, ge);
`ifdef BOARD_ADDR_CHECK_EN
        check("oob_err", {31'd0, ge}, 32'd1);
        check("oob_ack", {31'd0, ga}, 32'd0);
        check("oob_dat_r", {16'd0, rd}, 32'h0000);
        check("oob_revealed", {23'd0, revealed_cnt}, 32'd0);
        wb_access(1'b0, 8'h77, 16'h0, rd, lat, ga, ge);
        check("inb_ack", {31'd0, ga}, 32'd1);
        check("inb_err", {31'd0, ge}, 32'd0);
`else
        check("nochk_ack", {31'd0, ga}, 32'd1);
        check("nochk_err", {31'd0, ge}, 32'd0);
        check("nochk_revealed", {23'd0, revealed_cnt}, 32'd1);
        wb_access(1'b0, 8'h08, 16'h0, rd, lat, ga, ge);
        check("nochk_rd08", {16'd0, rd}, 32'h0004);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
